// File: rtl/ace_pkg.sv
// Shared types and ACE encodings for the line engine.
// Optional ACE_ACK_EN adds the RACK/WACK acknowledge state.
package ace_pkg;

  typedef enum logic [1:0] {
    OP_RS = 2'b00,
    OP_RU = 2'b01,
    OP_MU = 2'b10,
    OP_WC = 2'b11
  } op_e;

  localparam logic [3:0] SNP_RS = 4'b0001;
  localparam logic [3:0] SNP_RU = 4'b0111;
  localparam logic [3:0] SNP_MU = 4'b1100;
  localparam logic [2:0] SNP_WC = 3'b010;

  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [1:0] DOMAIN_INNER = 2'b01;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_AR   = 3'd1;
  localparam state_t S_R    = 3'd2;
  localparam state_t S_AW   = 3'd3;
  localparam state_t S_W    = 3'd4;
  localparam state_t S_B    = 3'd5;
  localparam state_t S_ACK  = 3'd6;
  localparam state_t S_DONE = 3'd7;

endpackage

// File: rtl/ace_beat_counter.sv
// Burst beat counter: clears, increments, saturates at limit.
// Shared by the R and W phases of ace_line_engine.
module ace_beat_counter #(
  parameter int N  = 4,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          inc,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] count,
  output logic          last
);

  assign last = (count == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !last) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ace_line_engine.sv
// ACE master that moves one cache line per request.
// Define ACE_ACK_EN to add the RACK/WACK acknowledge state.
module ace_line_engine
  import ace_pkg::*;
#(
  parameter int WIDTH_A    = 32,
  parameter int WIDTH_D    = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_op,
  input  logic [WIDTH_A-1:0]            req_addr,
  input  logic [LINE_WORDS*WIDTH_D-1:0] req_line,
  output logic                          done,
  output logic                          resp_err,
  output logic [LINE_WORDS*WIDTH_D-1:0] fill_line,
  output logic                          AR_VALID,
  input  logic                          AR_READY,
  output logic [WIDTH_A-1:0]            AR_ADDR,
  output logic [7:0]                    AR_LEN,
  output logic [1:0]                    AR_BURST,
  output logic [3:0]                    AR_SNOOP,
  output logic [1:0]                    AR_DOMAIN,
  input  logic                          R_VALID,
  output logic                          R_READY,
  input  logic [WIDTH_D-1:0]            RDATA,
  input  logic                          R_LAST,
  input  logic [3:0]                    RRESP,
  output logic                          AW_VALID,
  input  logic                          AW_READY,
  output logic [WIDTH_A-1:0]            AW_ADDR,
  output logic [7:0]                    AW_LEN,
  output logic [1:0]                    AW_BURST,
  output logic [2:0]                    AW_SNOOP,
  output logic [1:0]                    AW_DOMAIN,
  output logic                          W_VALID,
  input  logic                          W_READY,
  output logic [WIDTH_D-1:0]            W_DATA,
  output logic                          W_LAST,
  input  logic                          B_VALID,
  output logic                          B_READY,
  input  logic [1:0]                    BRESP,
  output logic                          RACK,
  output logic                          WACK
);

  localparam int CW  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int OFF = $clog2(LINE_WORDS * WIDTH_D / 8);
  localparam logic [WIDTH_A-1:0] AMASK = {WIDTH_A{1'b1}} << OFF;
  localparam logic [CW-1:0] LAST_W = CW'(LINE_WORDS - 1);

`ifdef ACE_ACK_EN
  localparam state_t S_RESP = S_ACK;
`else
  localparam state_t S_RESP = S_DONE;
`endif

  state_t state, nxt;
  op_e    op_q;
  logic [WIDTH_A-1:0] addr_q;
  logic [LINE_WORDS-1:0][WIDTH_D-1:0] line_q, fill_q;
  logic err_q, over_q;
  logic acc, r_hs, w_hs;
  logic [CW-1:0] cnt, lim;
  logic cnt_last, cnt_clr, cnt_inc;
  logic unused_rresp;

  assign acc  = (state == S_IDLE) && req_valid;
  assign r_hs = (state == S_R) && R_VALID;
  assign w_hs = (state == S_W) && W_READY;

  assign lim     = (op_q == OP_MU) ? '0 : LAST_W;
  assign cnt_clr = !((state == S_R) || (state == S_W));
  assign cnt_inc = r_hs || w_hs;

  ace_beat_counter #(.N(LINE_WORDS), .CW(CW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clr),
    .inc   (cnt_inc),
    .limit (lim),
    .count (cnt),
    .last  (cnt_last)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:
        if (req_valid)
          nxt = (op_e'(req_op) == OP_WC) ? S_AW : S_AR;
      S_AR:   if (AR_READY) nxt = S_R;
      S_R:    if (R_VALID && R_LAST) nxt = S_RESP;
      S_AW:   if (AW_READY) nxt = S_W;
      S_W:    if (W_READY && cnt_last) nxt = S_B;
      S_B:    if (B_VALID) nxt = S_RESP;
`ifdef ACE_ACK_EN
      S_ACK:  nxt = S_DONE;
`endif
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= OP_RS;
      addr_q <= '0;
      line_q <= '0;
      fill_q <= '0;
      err_q  <= 1'b0;
      over_q <= 1'b0;
    end else begin
      state <= nxt;
      if (acc) begin
        op_q   <= op_e'(req_op);
        addr_q <= req_addr & AMASK;
        line_q <= req_line;
        err_q  <= 1'b0;
        over_q <= 1'b0;
      end
      // Beats past AR_LEN are drained but never land in fill_line
      if (r_hs) begin
        if (RRESP[1:0] != 2'b00 || R_LAST != cnt_last)
          err_q <= 1'b1;
        if (cnt_last && !R_LAST)
          over_q <= 1'b1;
        if (op_q != OP_MU && !over_q)
          fill_q[cnt] <= RDATA;
      end
      if (state == S_B && B_VALID)
        err_q <= |BRESP;
    end
  end

  always_comb begin
    AR_SNOOP = SNP_RS;
    unique case (1'b1)
      (op_q == OP_RU): AR_SNOOP = SNP_RU;
      (op_q == OP_MU): AR_SNOOP = SNP_MU;
      default: ;
    endcase
  end

  assign req_ready = rst_n && (state == S_IDLE);
  assign AR_VALID  = (state == S_AR);
  assign AR_ADDR   = addr_q;
  assign AR_LEN    = (op_q == OP_MU) ? 8'd0 : 8'(LINE_WORDS - 1);
  assign AR_BURST  = BURST_INCR;
  assign AR_DOMAIN = DOMAIN_INNER;
  assign R_READY   = (state == S_R);
  assign AW_VALID  = (state == S_AW);
  assign AW_ADDR   = addr_q;
  assign AW_LEN    = 8'(LINE_WORDS - 1);
  assign AW_BURST  = BURST_INCR;
  assign AW_SNOOP  = SNP_WC;
  assign AW_DOMAIN = DOMAIN_INNER;
  assign W_VALID   = (state == S_W);
  assign W_DATA    = line_q[cnt];
  assign W_LAST    = (state == S_W) && cnt_last;
  assign B_READY   = (state == S_B);
  assign done      = (state == S_DONE);
  assign resp_err  = done && err_q;
  assign fill_line = fill_q;

`ifdef ACE_ACK_EN
  assign RACK = (state == S_ACK) && (op_q != OP_WC);
  assign WACK = (state == S_ACK) && (op_q == OP_WC);
`else
  assign RACK = 1'b0;
  assign WACK = 1'b0;
`endif

  assign unused_rresp = ^RRESP[3:2];

endmodule
